// File: rtl/alu_seq_unit_if.sv
// ----------------------------------------------------------------------------
// alu_seq_unit_if
// Request/response bundle between the EX-stage operand mux and alu_seq_unit.
//
// Signals:
//   in_valid / in_ready      request handshake (accept = in_valid & in_ready)
//   ALUop, funct3,
//   funct7_30, funct7_0      decode fields taken from the instruction word
//   op_a, op_b               operands (shift amount lives in op_b low bits)
//   out_valid / out_ready    result handshake (retire = out_valid & out_ready)
//   result, zero, illegal    registered result and its flags
//
// Modports:
//   master  the side that issues operations and consumes results
//   slave   the execution unit
// ----------------------------------------------------------------------------
interface alu_seq_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUop;
    logic [2:0]      funct3;
    logic            funct7_30;
    logic            funct7_0;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, ALUop, funct3, funct7_30, funct7_0, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, ALUop, funct3, funct7_30, funct7_0, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_seq_unit.sv
// ----------------------------------------------------------------------------
// alu_seq_unit
// Sequential RV32I integer execution unit for the EX stage of the multi-cycle
// core. Decodes ALUop/funct3/funct7 and executes the integer op set behind a
// valid/ready handshake on both sides. Simple ops finish in one cycle; shifts
// iterate SHAMT_STEP bits per cycle.
//
// Parameters:
//   XLEN        datapath width (power of 2, >= 8)
//   SHAMT_STEP  bits shifted per cycle (power of 2, 1..XLEN)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_unit_if slave modport (request, operands, result, flags)
//
// Optional feature:
//   ALU_SEQ_MUL_EN  when defined, ALUop=10/funct7_0=1/funct3=000 is MUL,
//                   computed by a radix-2 shift-add loop (XLEN+1 cycles).
//                   When undefined every M-extension encoding is illegal.
// ----------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int XLEN       = 32,
    parameter int SHAMT_STEP = 1
) (
    input logic           clk,
    input logic           rst_n,
    alu_seq_unit_if.slave bus
);

    localparam int SHW = $clog2(XLEN);
    // One extra bit so the counter can hold XLEN itself (MUL count, STEP=XLEN)
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHAMT_STEP);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [CW-1:0] XLEN_C = CW'(XLEN);
`endif

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
    } op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    op_t             op_dec;
    logic [XLEN-1:0] shift_q, shift_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
`ifdef ALU_SEQ_MUL_EN
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] mul_sum;
`endif

    logic [XLEN-1:0] simple_res;
    logic [XLEN-1:0] shift_next;
    logic [CW-1:0]   step;
    logic            in_ready;
    logic            out_valid;
    logic            accept;
    logic            retire;

    assign in_ready      = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
    assign out_valid     = (state_q == S_DONE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

    // ALUop 11 (I-type) only honours funct7_30 for SRAI; ADDI ignores it.
    always_comb begin
        op_dec = OP_ILL;
        case (bus.ALUop)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            default: begin
                case (bus.funct3)
                    3'b000:  op_dec = (bus.ALUop == 2'b10 && bus.funct7_30) ? OP_SUB : OP_ADD;
                    3'b001:  op_dec = OP_SLL;
                    3'b010:  op_dec = OP_SLT;
                    3'b011:  op_dec = OP_SLTU;
                    3'b100:  op_dec = OP_XOR;
                    3'b101:  op_dec = bus.funct7_30 ? OP_SRA : OP_SRL;
                    3'b110:  op_dec = OP_OR;
                    default: op_dec = OP_AND;
                endcase
                if (bus.ALUop == 2'b10 && bus.funct7_0) begin
`ifdef ALU_SEQ_MUL_EN
                    op_dec = (bus.funct3 == 3'b000) ? OP_MUL : OP_ILL;
`else
                    op_dec = OP_ILL;
`endif
                end
            end
        endcase
    end

    // Single-cycle results; shifts land here only when shamt is zero.
    always_comb begin
        simple_res = '0;
        case (op_dec)
            OP_ADD:  simple_res = bus.op_a + bus.op_b;
            OP_SUB:  simple_res = bus.op_a - bus.op_b;
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
            OP_XOR:  simple_res = bus.op_a ^ bus.op_b;
            OP_OR:   simple_res = bus.op_a | bus.op_b;
            OP_AND:  simple_res = bus.op_a & bus.op_b;
            OP_SLL, OP_SRL, OP_SRA: simple_res = bus.op_a;
            default: simple_res = '0;
        endcase
    end

    // Last step may be shorter than SHAMT_STEP.
    assign step = (rem_q < STEP_C) ? rem_q : STEP_C;

    always_comb begin
        shift_next = shift_q;
        case (op_q)
            OP_SLL:  shift_next = shift_q << step;
            OP_SRL:  shift_next = shift_q >> step;
            OP_SRA:  shift_next = XLEN'($signed(shift_q) >>> step);
            default: shift_next = shift_q;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // shift_q doubles as the left-shifting multiplicand while in S_MUL.
    assign mul_sum = mplier_q[0] ? (acc_q + shift_q) : acc_q;
`endif

    // Next-state and datapath update. A launch in the accept cycle overrides
    // whatever the current state would do, which is how DONE chains directly
    // into a new operation while retiring the old result.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        shift_d   = shift_q;
        rem_d     = rem_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d     = acc_q;
        mplier_d  = mplier_q;
`endif
        accept = bus.in_valid & in_ready;
        retire = out_valid & bus.out_ready;

        case (state_q)
            S_SHIFT: begin
                shift_d = shift_next;
                rem_d   = rem_q - step;
                if (rem_q == step) begin
                    state_d   = S_DONE;
                    result_d  = shift_next;
                    zero_d    = (shift_next == '0);
                    illegal_d = 1'b0;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                acc_d    = mul_sum;
                shift_d  = shift_q << 1;
                mplier_d = mplier_q >> 1;
                rem_d    = rem_q - 1'b1;
                if (rem_q == 1) begin
                    state_d   = S_DONE;
                    result_d  = mul_sum;
                    zero_d    = (mul_sum == '0);
                    illegal_d = 1'b0;
                end
            end
`endif
            S_DONE: begin
                if (retire) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            op_d    = op_dec;
            shift_d = bus.op_a;
            rem_d   = {1'b0, bus.op_b[SHW-1:0]};
            if ((op_dec == OP_SLL || op_dec == OP_SRL || op_dec == OP_SRA) &&
                (bus.op_b[SHW-1:0] != '0)) begin
                state_d = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
            end else if (op_dec == OP_MUL) begin
                state_d  = S_MUL;
                acc_d    = '0;
                mplier_d = bus.op_b;
                rem_d    = XLEN_C;
`endif
            end else begin
                state_d   = S_DONE;
                result_d  = simple_res;
                zero_d    = (simple_res == '0);
                illegal_d = (op_dec == OP_ILL);
            end
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            shift_q   <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            shift_q   <= shift_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_unit
// Self-checking bench for alu_seq_unit. The main instance uses SHAMT_STEP=1;
// a second instance with SHAMT_STEP=4 covers multi-bit and short final steps.
// Expected results come from a reference model, are queued at accept time and
// popped when the DUT retires a result. Honours ALU_SEQ_MUL_EN like the RTL.
// ----------------------------------------------------------------------------
module tb_alu_seq_unit;

    localparam int XLEN = 32;
    localparam int SHW  = $clog2(XLEN);

    typedef struct {
        logic [XLEN-1:0] res;
        logic            zero;
        logic            ill;
        int              lat;
        int              acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    logic prev_retire = 1'b0;

    alu_seq_unit_if #(.XLEN(XLEN)) bus ();
    alu_seq_unit_if #(.XLEN(XLEN)) bus4 ();

    alu_seq_unit #(.XLEN(XLEN), .SHAMT_STEP(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_seq_unit #(.XLEN(XLEN), .SHAMT_STEP(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Free-running clock and a cycle counter used for latency measurement
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: count it, report a mismatch
    task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model of the unit: result, flags and accept-to-valid latency
    function automatic exp_t model(input logic [1:0] aluop, input logic [2:0] f3,
                                   input logic f30, input logic f0,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input int stp);
        exp_t e;
        logic [SHW-1:0] shv;
        int sh;
        shv   = b[SHW-1:0];
        sh    = int'(shv);
        e.res = '0;
        e.ill = 1'b0;
        e.lat = 1;
        e.acc = 0;
        if (aluop == 2'b00) e.res = a + b;
        else if (aluop == 2'b01) e.res = a - b;
        else if (aluop == 2'b10 && f0) begin
`ifdef ALU_SEQ_MUL_EN
            if (f3 == 3'b000) begin
                e.res = a * b;
                e.lat = XLEN + 1;
            end else e.ill = 1'b1;
`else
            e.ill = 1'b1;
`endif
        end else begin
            case (f3)
                3'b000: e.res = (aluop == 2'b10 && f30) ? a - b : a + b;
                3'b001: e.res = a << sh;
                3'b010: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
                3'b011: e.res = (a < b) ? 1 : 0;
                3'b100: e.res = a ^ b;
                3'b101: e.res = f30 ? XLEN'($signed(a) >>> sh) : a >> sh;
                3'b110: e.res = a | b;
                default: e.res = a & b;
            endcase
            if ((f3 == 3'b001 || f3 == 3'b101) && sh > 0) e.lat = 1 + (sh + stp - 1) / stp;
        end
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Drive one request on the main instance, wait (bounded) for accept and
    // queue its expectation. Called and returns at posedge+1.
    task automatic applyStimulus(input logic [1:0] aluop, input logic [2:0] f3,
                                 input logic f30, input logic f0,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exp_t e;
        int   waited;
        e = model(aluop, f3, f30, f0, a, b, 1);
        bus.ALUop     = aluop;
        bus.funct3    = f3;
        bus.funct7_30 = f30;
        bus.funct7_0  = f0;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.in_valid  = 1'b1;
        waited = 0;
        #1;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end else begin
            e.acc = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Drive one request on the SHAMT_STEP=4 instance and check it directly
    task automatic applyStimulusStep4(input logic [1:0] aluop, input logic [2:0] f3,
                                      input logic f30, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        exp_t e;
        int   n;
        e = model(aluop, f3, f30, 1'b0, a, b, 4);
        bus4.ALUop     = aluop;
        bus4.funct3    = f3;
        bus4.funct7_30 = f30;
        bus4.funct7_0  = 1'b0;
        bus4.op_a      = a;
        bus4.op_b      = b;
        bus4.in_valid  = 1'b1;
        #1;
        checkOutput("step4_in_ready", XLEN'(bus4.in_ready), 1);
        e.acc = cyc + 1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        n = 0;
        while (!bus4.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus4.out_valid) checkOutput("step4_timeout", 0, 1);
        else begin
            checkOutput("step4_latency", XLEN'(cyc - e.acc + 1), XLEN'(e.lat));
            checkOutput("step4_result", bus4.result, e.res);
        end
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until every queued expectation has been retired
    task automatic waitIdle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || bus.out_valid) checkOutput("drain_timeout", 0, 1);
    endtask

    // Monitor on the falling edge: latency when a fresh result shows up,
    // result/flags when it retires; a result with nothing queued is stale.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid  = 1'b0;
            prev_retire = 1'b0;
        end else begin
            if (bus.out_valid && (!prev_valid || prev_retire)) begin
                if (sb.size() == 0) checkOutput("stale_result", 1, 0);
                else checkOutput("latency", XLEN'(cyc - sb[0].acc + 1), XLEN'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                checkOutput("result", bus.result, mon_e.res);
                checkOutput("zero", XLEN'(bus.zero), XLEN'(mon_e.zero));
                checkOutput("illegal", XLEN'(bus.illegal), XLEN'(mon_e.ill));
            end
            prev_valid  = bus.out_valid;
            prev_retire = bus.out_valid && bus.out_ready;
        end
    end

    // Last-resort guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        exp_t hold_e;
        logic any_ready;
        int   n;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.ALUop     = 2'b00;
        bus.funct3    = 3'b000;
        bus.funct7_30 = 1'b0;
        bus.funct7_0  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        bus4.ALUop     = 2'b00;
        bus4.funct3    = 3'b000;
        bus4.funct7_30 = 1'b0;
        bus4.funct7_0  = 1'b0;
        bus4.op_a      = '0;
        bus4.op_b      = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", XLEN'(bus.out_valid), 0);
        checkOutput("rst_result", bus.result, 0);
        checkOutput("rst_zero", XLEN'(bus.zero), 0);
        checkOutput("rst_illegal", XLEN'(bus.illegal), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", XLEN'(bus.in_ready), 1);

        // Simple ops back to back (each accept overlaps the previous retire)
        applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7);
        applyStimulus(2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9);
        applyStimulus(2'b10, 3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 3'b010, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
        applyStimulus(2'b00, 3'b111, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020);
        applyStimulus(2'b11, 3'b000, 1'b1, 1'b0, 32'd3, 32'd4);
        applyStimulus(2'b11, 3'b000, 1'b0, 1'b1, 32'd10, 32'd20);
        applyStimulus(2'b10, 3'b110, 1'b0, 1'b0, 32'h1200_0034, 32'h0056_0000);
        applyStimulus(2'b11, 3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        applyStimulus(2'b10, 3'b001, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020);
        applyStimulus(2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4);
        applyStimulus(2'b11, 3'b001, 1'b1, 1'b0, 32'h0000_0003, 32'd5);
        applyStimulus(2'b11, 3'b101, 1'b1, 1'b0, 32'h8000_0010, 32'd2);

        // Long arithmetic shift: in_ready must stay low until the result
        applyStimulus(2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd31);
        any_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 60) begin
            if (bus.in_ready) any_ready = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("shift_in_ready", XLEN'(any_ready), 0);
        waitIdle();

        // M-extension encodings
        applyStimulus(2'b10, 3'b000, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0001_0001);
        applyStimulus(2'b10, 3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0005);
        waitIdle();

        // Backpressure: result and flags held, no new request accepted
        bus.out_ready = 1'b0;
        hold_e = model(2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0F0F_0000, 1);
        applyStimulus(2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0F0F_0000);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", XLEN'(bus.out_valid), 1);
            checkOutput("bp_result", bus.result, hold_e.res);
            checkOutput("bp_zero", XLEN'(bus.zero), XLEN'(hold_e.zero));
            checkOutput("bp_in_ready", XLEN'(bus.in_ready), 0);
            @(posedge clk);
            #1;
        end
        // Retire and accept in the same cycle
        bus.out_ready = 1'b1;
        applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1);
        waitIdle();

        // Reset in the middle of a 31-bit shift
        applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 32'h1234_5678, 32'd0);
        applyStimulus(2'b11, 3'b001, 1'b0, 1'b0, 32'd1, 32'd31);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", XLEN'(bus.out_valid), 0);
        checkOutput("abort_result", bus.result, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_in_ready", XLEN'(bus.in_ready), 1);
        repeat (40) @(posedge clk);
        #1;

        // SHAMT_STEP=4 instance: full steps, short last step, exact multiple
        applyStimulusStep4(2'b10, 3'b001, 1'b0, 32'd1, 32'd31);
        applyStimulusStep4(2'b10, 3'b101, 1'b1, 32'h8000_0000, 32'd6);
        applyStimulusStep4(2'b11, 3'b101, 1'b0, 32'h0000_0080, 32'd3);
        applyStimulusStep4(2'b11, 3'b001, 1'b0, 32'h0000_00A5, 32'd8);

        waitIdle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
